// File: rtl/mul_share_arb_pkg.sv
// +------------------------------------------------------------------------+
// | mul_share_arb_pkg                                                      |
// | Shared types for the multiplier-sharing arbiter.                       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package mul_share_arb_pkg;

   typedef enum logic [0:0] {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Requester ids are sized for the largest supported requester count.
   localparam int N_MAX = 8;
   localparam int ID_W  = $clog2(N_MAX);

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

`default_nettype wire

// File: rtl/mul_share_rr_pick.sv
// +------------------------------------------------------------------------+
// | mul_share_rr_pick                                                      |
// | Combinational rotate-priority picker: search starts at last+1, wraps.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module mul_share_rr_pick
   import mul_share_arb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] last,
   output logic [N-1:0]    gnt
);

   // Walk distances from farthest to nearest so the nearest request wins.
   always_comb begin
      gnt = '0;
      for (int k = N; k >= 1; k--) begin
         for (int j = 0; j < N; j++) begin
            if (req[j] && (j == ((int'(last) + k) % N))) begin
               gnt    = '0;
               gnt[j] = 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mul_share_arb.sv
// +------------------------------------------------------------------------+
// | mul_share_arb                                                          |
// | Round-robin scheduler sharing one W x W multiplier among N requesters, |
// | with tagged, in-order response routing. Optional grant locking is      |
// | enabled by defining MUL_SHARE_ARB_LOCK_EN.                             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module mul_share_arb
   import mul_share_arb_pkg::*;
#(
   parameter int W        = 16,
   parameter int N        = 3,
   parameter int MUL_LAT  = 1,
   parameter int LOCK_MAX = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_valid,
   output logic [N-1:0]     req_ready,
   input  logic [N*W-1:0]   req_a,
   input  logic [N*W-1:0]   req_b,
   input  logic [N-1:0]     req_lock,
   output logic [N-1:0]     rsp_valid,
   output logic [2*W:0]     rsp_prod,
   output logic             busy,
   output logic             mul_en,
   output logic [W-1:0]     mul_a,
   output logic [W-1:0]     mul_b,
   input  logic [2*W:0]     mul_prod
);

   localparam int PW = 2*W + 1;

   logic [N-1:0]    pick_gnt;
   logic [N-1:0]    grant;
   logic [N-1:0]    hs;
   logic            hs_any;
   logic [ID_W-1:0] hs_id;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic            force_rel;

   logic [ID_W-1:0] last_q, last_d;
   logic            mul_en_q, mul_en_d;
   logic [W-1:0]    mul_a_q, mul_a_d;
   logic [W-1:0]    mul_b_q, mul_b_d;
   tag_t            tag_q [MUL_LAT+1];
   tag_t            tag_d [MUL_LAT+1];
   logic [N-1:0]    rsp_valid_q, rsp_valid_d;
   logic [PW-1:0]   rsp_prod_q, rsp_prod_d;

`ifdef MUL_SHARE_ARB_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   arb_state_e      state_q, state_d;
   logic [ID_W-1:0] owner_q, owner_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic            hs_lock;
   logic            owner_valid;
`else
   logic            unused_lock;
   assign unused_lock = ^{req_lock, (LOCK_MAX != 0)};
`endif

   mul_share_rr_pick #(
      .N (N)
   ) u_pick (
      .req  (req_valid),
      .last (last_q),
      .gnt  (pick_gnt)
   );

   always_comb begin
      grant = pick_gnt;
`ifdef MUL_SHARE_ARB_LOCK_EN
      if (state_q == LOCKED) begin
         for (int i = 0; i < N; i++) begin
            grant[i] = req_valid[i] && (owner_q == ID_W'(i));
         end
      end
`endif
      req_ready = rst ? '0 : grant;
      hs        = req_valid & req_ready;
      hs_any    = |hs;
      hs_id     = '0;
      op_a      = '0;
      op_b      = '0;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            hs_id = ID_W'(i);
            op_a  = req_a[i*W +: W];
            op_b  = req_b[i*W +: W];
         end
      end
   end

`ifdef MUL_SHARE_ARB_LOCK_EN
   always_comb begin
      hs_lock     = 1'b0;
      owner_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) hs_lock = req_lock[i];
         if (owner_q == ID_W'(i)) owner_valid = req_valid[i];
      end
      state_d    = state_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      force_rel  = 1'b0;
      case (state_q)
         ARB: begin
            if (hs_any && hs_lock) begin
               state_d    = LOCKED;
               owner_d    = hs_id;
               lock_cnt_d = '0;
            end
         end
         LOCKED: begin
            // Forced release rotates the pointer past the owner.
            if (lock_cnt_q == CNT_W'(LOCK_MAX)) begin
               state_d   = ARB;
               force_rel = 1'b1;
            end else if (!owner_valid || (hs_any && !hs_lock)) begin
               state_d = ARB;
            end else begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end
         default: state_d = ARB;
      endcase
   end
`else
   assign force_rel = 1'b0;
`endif

   always_comb begin
      last_d = hs_any ? hs_id : last_q;
`ifdef MUL_SHARE_ARB_LOCK_EN
      if (force_rel) last_d = owner_q;
`endif
      mul_en_d = hs_any;
      mul_a_d  = hs_any ? op_a : mul_a_q;
      mul_b_d  = hs_any ? op_b : mul_b_q;

      tag_d[0].valid = hs_any;
      tag_d[0].id    = hs_id;
      for (int k = 1; k <= MUL_LAT; k++) begin
         tag_d[k] = tag_q[k-1];
      end

      rsp_valid_d = '0;
      rsp_prod_d  = rsp_prod_q;
      if (tag_q[MUL_LAT].valid) begin
         rsp_prod_d = mul_prod;
         for (int i = 0; i < N; i++) begin
            rsp_valid_d[i] = (tag_q[MUL_LAT].id == ID_W'(i));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q      <= ID_W'(N-1);
         mul_en_q    <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         rsp_valid_q <= '0;
         rsp_prod_q  <= '0;
         for (int k = 0; k <= MUL_LAT; k++) begin
            tag_q[k] <= '0;
         end
`ifdef MUL_SHARE_ARB_LOCK_EN
         state_q    <= ARB;
         owner_q    <= '0;
         lock_cnt_q <= '0;
`endif
      end else begin
         last_q      <= last_d;
         mul_en_q    <= mul_en_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_prod_q  <= rsp_prod_d;
         for (int k = 0; k <= MUL_LAT; k++) begin
            tag_q[k] <= tag_d[k];
         end
`ifdef MUL_SHARE_ARB_LOCK_EN
         state_q    <= state_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
`endif
      end
   end

   always_comb begin
      busy = mul_en_q;
      for (int k = 0; k <= MUL_LAT; k++) begin
         busy = busy | tag_q[k].valid;
      end
   end

   assign mul_en    = mul_en_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_prod  = rsp_prod_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arb.sv
// +------------------------------------------------------------------------+
// | tb_mul_share_arb                                                       |
// | Self-checking bench for mul_share_arb with an ideal multiplier model.  |
// | Lock scenarios are compiled in when MUL_SHARE_ARB_LOCK_EN is defined.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_mul_share_arb;

   localparam int W        = 16;
   localparam int N        = 3;
   localparam int L        = 1;
   localparam int LOCK_MAX = 15;
   localparam int PW       = 2*W + 1;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid, req_ready, req_lock, rsp_valid;
   logic [N*W-1:0] req_a, req_b;
   logic [PW-1:0]  rsp_prod, mul_prod;
   logic           busy, mul_en;
   logic [W-1:0]   mul_a, mul_b;

   always #5 clk = ~clk;

   mul_share_arb #(
      .W (W), .N (N), .MUL_LAT (L), .LOCK_MAX (LOCK_MAX)
   ) dut (
      .clk (clk), .rst (rst),
      .req_valid (req_valid), .req_ready (req_ready),
      .req_a (req_a), .req_b (req_b), .req_lock (req_lock),
      .rsp_valid (rsp_valid), .rsp_prod (rsp_prod), .busy (busy),
      .mul_en (mul_en), .mul_a (mul_a), .mul_b (mul_b), .mul_prod (mul_prod)
   );

   // Ideal multiplier: product appears L cycles after the operands.
   logic [PW-1:0] mpipe [L];
   always @(posedge clk) begin
      mpipe[0] <= PW'(mul_a) * PW'(mul_b);
      for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
   end
   assign mul_prod = mpipe[L-1];

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   // Reference model state
   typedef struct { int due; int id; logic [PW-1:0] prod; } rsp_t;
   typedef struct { int c; logic [N-1:0] rv; } log_t;
   rsp_t          q[$];
   log_t          rsp_log[$];
   int            m_last = N-1;
   bit            m_locked = 0;
   int            m_owner = 0;
   int            m_cnt = 0;
   logic          m_en = 1'b0;
   logic [W-1:0]  m_a = '0, m_b = '0;
   logic [N-1:0]  m_rv = '0;
   logic [PW-1:0] m_prod = '0;
   logic [N-1:0]  last_ready;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic logic [W-1:0] slot(input logic [N*W-1:0] v, input int i);
      return v[i*W +: W];
   endfunction

   function automatic int model_grant();
      int j;
      if (rst) return -1;
      if (m_locked) return req_valid[m_owner] ? m_owner : -1;
      for (int k = 1; k <= N; k++) begin
         j = (m_last + k) % N;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   // One clock: check the grant mid-cycle, advance the model, check registered outputs.
   task automatic step();
      int   g;
      bit   r;
      rsp_t e;
      #4;
      g = model_grant();
      r = rst;
      last_ready = req_ready;
      chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
      if (r) begin
         q.delete();
         m_en = 1'b0; m_a = '0; m_b = '0; m_last = N-1; m_locked = 0; m_cnt = 0;
      end else begin
         if (g >= 0) begin
            m_en = 1'b1;
            m_a = slot(req_a, g);
            m_b = slot(req_b, g);
            e.due = cyc + L + 2; e.id = g; e.prod = PW'(m_a) * PW'(m_b);
            q.push_back(e);
            m_last = g;
         end else begin
            m_en = 1'b0;
         end
`ifdef MUL_SHARE_ARB_LOCK_EN
         if (!m_locked) begin
            if (g >= 0 && req_lock[g]) begin m_locked = 1; m_owner = g; m_cnt = 0; end
         end else if (m_cnt == LOCK_MAX) begin
            m_locked = 0; m_last = m_owner;
         end else if (!req_valid[m_owner] || (g == m_owner && !req_lock[m_owner])) begin
            m_locked = 0;
         end else begin
            m_cnt++;
         end
`endif
      end
      @(posedge clk);
      #1;
      cyc++;
      m_rv = '0;
      if (r) begin
         m_prod = '0;
      end else if (q.size() > 0 && q[0].due == cyc) begin
         m_rv   = N'(1 << q[0].id);
         m_prod = q[0].prod;
         void'(q.pop_front());
      end
      chk("mul_en", 64'(mul_en), 64'(m_en));
      chk("mul_a", 64'(mul_a), 64'(m_a));
      chk("mul_b", 64'(mul_b), 64'(m_b));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
      chk("rsp_prod", 64'(rsp_prod), 64'(m_prod));
      chk("busy", 64'(busy), 64'(q.size() != 0));
      if (rsp_valid != '0) begin
         log_t l;
         l.c = cyc; l.rv = rsp_valid;
         rsp_log.push_back(l);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; req_lock = '0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
   endtask

   typedef struct {
      int            id;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [PW-1:0] prod;
   } vec_t;

   vec_t          vt [5];
   int            exp_seq [6];
   int            lat;
   int            cnt;
   logic [N-1:0]  rv_seen;
   logic [PW-1:0] prod_seen;

   initial begin
      rst = 1'b1; req_valid = '0; req_lock = '0; req_a = '0; req_b = '0;
      vt[0] = '{0, 16'h0003, 16'h0005, 33'h0_0000_000F};
      vt[1] = '{1, 16'hFFFF, 16'hFFFF, 33'h0_FFFE_0001};
      vt[2] = '{2, 16'h0000, 16'h1234, 33'h0_0000_0000};
      vt[3] = '{0, 16'hFFFF, 16'h0001, 33'h0_0000_FFFF};
      vt[4] = '{2, 16'h8000, 16'h0002, 33'h0_0001_0000};
      exp_seq = '{1, 2, 4, 1, 2, 4};

      do_reset();
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_mul_en", 64'(mul_en), 64'd0);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_prod", 64'(rsp_prod), 64'd0);

      // Directed single-op vectors: latency, owner and exact product.
      for (int v = 0; v < 5; v++) begin
         req_a = '0; req_b = '0;
         set_op(vt[v].id, vt[v].a, vt[v].b);
         req_valid = N'(1 << vt[v].id);
         step();
         req_valid = '0;
         lat = -1; rv_seen = '0; prod_seen = '0;
         for (int k = 1; k <= 6; k++) begin
            step();
            if (rsp_valid != '0 && lat < 0) begin
               lat = k; rv_seen = rsp_valid; prod_seen = rsp_prod;
            end
         end
         chk("vec_latency", 64'(lat), 64'(L + 1));
         chk("vec_owner", 64'(rv_seen), 64'(1 << vt[v].id));
         chk("vec_prod", 64'(prod_seen), 64'(vt[v].prod));
      end

      // All three requesting: strict rotation, one response per cycle in order.
      do_reset();
      rsp_log.delete();
      for (int i = 0; i < N; i++) set_op(i, W'(i + 2), W'(i + 7));
      req_valid = '1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rr_grant", 64'(last_ready), 64'(exp_seq[k]));
      end
      req_valid = '0;
      for (int k = 0; k < 5; k++) step();
      chk("rr_rsp_count", 64'(rsp_log.size()), 64'd6);
      for (int k = 0; k < 6 && k < rsp_log.size(); k++) begin
         chk("rr_rsp_order", 64'(rsp_log[k].rv), 64'(exp_seq[k]));
         chk("rr_rsp_cycle", 64'(rsp_log[k].c - rsp_log[0].c), 64'(k));
      end

      // Reset with two ops in flight drops both responses.
      do_reset();
      rsp_log.delete();
      set_op(0, 16'h0011, 16'h0022);
      req_valid = 3'b001;
      step(); step();
      req_valid = '0;
      chk("flight_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) step();
      chk("flight_no_rsp", 64'(rsp_log.size()), 64'd0);
      chk("flight_idle", 64'(busy), 64'd0);
      req_valid = '1;
      step();
      chk("flight_req0_first", 64'(last_ready), 64'd1);
      req_valid = '0;
      for (int k = 0; k < 5; k++) step();

`ifdef MUL_SHARE_ARB_LOCK_EN
      // Lock held for three ops, released on the fourth; rotation resumes at 0.
      do_reset();
      req_valid = 3'b100; req_lock = 3'b100;
      step();
      chk("lock_grant0", 64'(last_ready), 64'd4);
      req_valid = 3'b111;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("lock_grant_hold", 64'(last_ready), 64'd4);
      end
      req_lock = '0;
      step();
      chk("lock_grant_release", 64'(last_ready), 64'd4);
      step();
      chk("lock_next_grant", 64'(last_ready), 64'd1);
      req_valid = '0;
      for (int k = 0; k < 5; k++) step();

      // Owner never releases: counter forces release, then requester 2 goes.
      do_reset();
      req_valid = 3'b010; req_lock = 3'b010;
      step();
      req_valid = 3'b110;
      cnt = 1;
      for (int k = 0; k < 40 && last_ready == 3'b010; k++) begin
         step();
         if (last_ready == 3'b010) cnt++;
      end
      chk("force_hold_count", 64'(cnt), 64'(LOCK_MAX + 2));
      chk("force_next_grant", 64'(last_ready), 64'd4);
      req_valid = '0; req_lock = '0;
      for (int k = 0; k < 5; k++) step();
`endif

      // Randomized traffic against the reference model.
      do_reset();
      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(0, 79) == 0);
         req_valid = N'($urandom);
         req_lock  = N'($urandom);
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 5))
               0:       set_op(i, '1, '1);
               1:       set_op(i, '0, W'($urandom));
               default: set_op(i, W'($urandom), W'($urandom));
            endcase
         end
         step();
      end
      rst = 1'b0; req_valid = '0; req_lock = '0;
      for (int k = 0; k < 6; k++) step();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
